// File: rtl/decoder_3to8_pulse_pkg.sv
// -----------------------------------------------------------------------------
// decoder_3to8_pulse_pkg
// Shared definitions for the 3-to-8 pulse decoder:
//   state_t      - controller state encoding (IDLE / DRIVE / GAP)
//   ONEHOT_ZERO  - value driven on the one-hot output when no line is active
//   lengths_ok() - legality check for the pulse/gap lengths against the
//                  counter width, used at elaboration time by the top level
// -----------------------------------------------------------------------------
package decoder_3to8_pulse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [7:0] ONEHOT_ZERO = 8'h00;

   // Both lengths must fit in the counter and in 1..255 / 0..255.
   function automatic bit lengths_ok(input int pulse_len,
                                     input int gap_len,
                                     input int cw);
      longint lim;
      lim = (longint'(1) << cw) - 1;
      return (pulse_len >= 1) && (pulse_len <= 255) && (pulse_len <= lim) &&
             (gap_len   >= 0) && (gap_len   <= 255) && (gap_len   <= lim);
   endfunction

endpackage

// File: rtl/decoder_3to8_pulse_if.sv
// -----------------------------------------------------------------------------
// decoder_3to8_pulse_if
// Code-input handshake of the pulse decoder.
//   in_valid : producer -> decoder, in_code is valid this cycle
//   in_ready : decoder  -> producer, a code can be accepted this cycle
//   in_code  : producer -> decoder, 3-bit binary code 0..7
// An accept happens on a rising clock edge with in_valid && in_ready.
// -----------------------------------------------------------------------------
interface decoder_3to8_pulse_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_code;

   modport master (
      output in_valid,
      output in_code,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_code,
      output in_ready
   );
endinterface

// File: rtl/decoder_3to8_pulse_dec_3to8.sv
// -----------------------------------------------------------------------------
// dec_3to8
// Purely combinational 3-bit binary to 8-bit one-hot decoder.
//   code   : input  [2:0] binary code
//   onehot : output [7:0] bit 'code' set, all others clear
// -----------------------------------------------------------------------------
module dec_3to8
   import decoder_3to8_pulse_pkg::*;
(
   input  logic [2:0] code,
   output logic [7:0] onehot
);

   always_comb begin
      onehot       = ONEHOT_ZERO;
      onehot[code] = 1'b1;
   end

endmodule

// File: rtl/decoder_3to8_pulse.sv
// -----------------------------------------------------------------------------
// decoder_3to8_pulse
// Accepts a 3-bit code over a valid/ready handshake and drives the matching
// one-hot line for PULSE_LEN cycles, followed by GAP_LEN all-zero cycles.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   en    : allows new codes to be accepted; a running pulse/gap always ends
//   in_if : code handshake (slave side)
//   out   : registered one-hot output, 8'h00 when not driving
//   busy  : high in DRIVE or GAP
//   done  : high in the final DRIVE cycle of each pulse
// -----------------------------------------------------------------------------
module decoder_3to8_pulse
   import decoder_3to8_pulse_pkg::*;
#(
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 1,
   parameter int CW        = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   decoder_3to8_pulse_if.slave  in_if,
   output logic [7:0]           out,
   output logic                 busy,
   output logic                 done
);

   generate
      if (!lengths_ok(PULSE_LEN, GAP_LEN, CW)) begin : g_bad_params
         $error("decoder_3to8_pulse: PULSE_LEN/GAP_LEN out of range for CW");
      end
   endgenerate

   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
   localparam bit            GAP_ON     = (GAP_LEN > 0);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      out_q, out_d;
   logic [7:0]      dec_onehot;
   logic            last_cyc;
   logic            ready;
   logic            accept;

   dec_3to8 u_dec (
      .code   (in_if.in_code),
      .onehot (dec_onehot)
   );

   assign last_cyc = (cnt_q == '0);

   // Ready is gated by rst_n so the handshake is closed while in reset.
   // Without a gap, the last DRIVE cycle may accept and chain pulses back
   // to back with no zero cycle in between.
   always_comb begin
      ready = 1'b0;
      if (rst_n && en) begin
         case (state_q)
            ST_IDLE:  ready = 1'b1;
            ST_DRIVE: ready = !GAP_ON && last_cyc;
            ST_GAP:   ready = last_cyc;
            default:  ready = 1'b0;
         endcase
      end
   end

   assign accept = in_if.in_valid && ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_DRIVE;
               cnt_d   = PULSE_LOAD;
               out_d   = dec_onehot;
            end
         end
         ST_DRIVE: begin
            if (!last_cyc) begin
               cnt_d = cnt_q - 1'b1;
            end else if (accept) begin
               cnt_d = PULSE_LOAD;
               out_d = dec_onehot;
            end else if (GAP_ON) begin
               state_d = ST_GAP;
               cnt_d   = GAP_LOAD;
               out_d   = ONEHOT_ZERO;
            end else begin
               state_d = ST_IDLE;
               out_d   = ONEHOT_ZERO;
            end
         end
         ST_GAP: begin
            if (!last_cyc) begin
               cnt_d = cnt_q - 1'b1;
            end else if (accept) begin
               state_d = ST_DRIVE;
               cnt_d   = PULSE_LOAD;
               out_d   = dec_onehot;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            out_d   = ONEHOT_ZERO;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         out_q   <= ONEHOT_ZERO;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   assign in_if.in_ready = ready;
   assign out            = out_q;
   assign busy           = (state_q != ST_IDLE);
   assign done           = (state_q == ST_DRIVE) && last_cyc;

endmodule

// File: tb/tb_decoder_3to8_pulse.sv
// -----------------------------------------------------------------------------
// tb_decoder_3to8_pulse
// Drives two decoders from the same stimulus: A with PULSE_LEN=4/GAP_LEN=1
// and B with PULSE_LEN=1/GAP_LEN=0. Each accepted code pushes the expected
// per-cycle output (one-hot for the pulse, zeros for the gap) onto that
// decoder's queue; every cycle one entry is popped and compared.
// -----------------------------------------------------------------------------
module tb_decoder_3to8_pulse;

   typedef struct packed {
      logic [7:0] out;
      logic       done;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       valid;
   logic [2:0] code;

   logic [7:0] out_a, out_b;
   logic       busy_a, busy_b, done_a, done_b;

   int n_vec = 0;
   int n_mis = 0;

   ent_t qa[$];
   ent_t qb[$];
   logic acc_a, acc_b;

   decoder_3to8_pulse_if ifa ();
   decoder_3to8_pulse_if ifb ();

   assign ifa.in_valid = valid;
   assign ifa.in_code  = code;
   assign ifb.in_valid = valid;
   assign ifb.in_code  = code;

   decoder_3to8_pulse #(.PULSE_LEN(4), .GAP_LEN(1), .CW(8)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .in_if (ifa),
      .out   (out_a),
      .busy  (busy_a),
      .done  (done_a)
   );

   decoder_3to8_pulse #(.PULSE_LEN(1), .GAP_LEN(0), .CW(8)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .in_if (ifb),
      .out   (out_b),
      .busy  (busy_b),
      .done  (done_b)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push_pulse(input int d, input logic [2:0] c);
      int         plen, glen;
      logic [7:0] oh;
      ent_t       e;
      plen = (d == 0) ? 4 : 1;
      glen = (d == 0) ? 1 : 0;
      oh   = 8'd1 << c;
      for (int i = 0; i < plen; i++) begin
         e.out  = oh;
         e.done = (i == plen - 1);
         if (d == 0) qa.push_back(e); else qb.push_back(e);
      end
      for (int i = 0; i < glen; i++) begin
         e = '0;
         if (d == 0) qa.push_back(e); else qb.push_back(e);
      end
   endtask

   // One clock cycle: check outputs left by the previous edge, drive new
   // inputs, check ready and record any accept for the coming edge.
   task automatic cycle(input logic e, input logic v, input logic [2:0] c);
      ent_t ea, eb;
      logic ba, bb, ra, rb;
      @(negedge clk);
      ea = '0; ba = 1'b0;
      if (qa.size() > 0) begin ea = qa.pop_front(); ba = 1'b1; end
      eb = '0; bb = 1'b0;
      if (qb.size() > 0) begin eb = qb.pop_front(); bb = 1'b1; end
      chk("a_out",    out_a,  ea.out);
      chk("a_busy",   busy_a, ba);
      chk("a_done",   done_a, ea.done);
      chk("a_onehot", ($countones(out_a) <= 1), 1'b1);
      chk("b_out",    out_b,  eb.out);
      chk("b_busy",   busy_b, bb);
      chk("b_done",   done_b, eb.done);
      chk("b_onehot", ($countones(out_b) <= 1), 1'b1);
      en = e; valid = v; code = c;
      #1;
      ra = e && (qa.size() == 0);
      rb = e && (qb.size() == 0);
      chk("a_ready", ifa.in_ready, ra);
      chk("b_ready", ifb.in_ready, rb);
      acc_a = v && ra;
      acc_b = v && rb;
      if (acc_a) push_pulse(0, c);
      if (acc_b) push_pulse(1, c);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 3'($urandom_range(0, 7)));
   endtask

   // Reset asserted between edges: outputs must clear without a clock edge.
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_a_out",   out_a,        8'h00);
      chk("rst_a_busy",  busy_a,       1'b0);
      chk("rst_a_done",  done_a,       1'b0);
      chk("rst_a_ready", ifa.in_ready, 1'b0);
      chk("rst_b_out",   out_b,        8'h00);
      chk("rst_b_busy",  busy_b,       1'b0);
      chk("rst_b_done",  done_b,       1'b0);
      chk("rst_b_ready", ifb.in_ready, 1'b0);
      qa.delete();
      qb.delete();
      valid = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_hold_a_out",  out_a,  8'h00);
      chk("rst_hold_a_done", done_a, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      rst_n = 1'b1;
      en    = 1'b1;
      valid = 1'b0;
      code  = 3'd0;
      acc_a = 1'b0;
      acc_b = 1'b0;

      // Power-on reset.
      async_reset();
      idle(2);

      // Single code 5.
      cycle(1'b1, 1'b1, 3'd5);
      idle(8);

      // Sweep 0..7 with valid held high; A takes a new code every 5 cycles.
      for (int c = 0; c < 8; c++) begin
         n = 0;
         do begin
            cycle(1'b1, 1'b1, 3'(c));
            n++;
         end while (!acc_a && n < 20);
         chk("sweep_accept", acc_a, 1'b1);
         chk("sweep_period", n, (c == 0) ? 1 : 5);
      end
      idle(8);

      // Back-to-back codes 3 then 6 (B chains without a zero cycle).
      cycle(1'b1, 1'b1, 3'd3);
      cycle(1'b1, 1'b1, 3'd6);
      idle(8);

      // Reset during the second cycle of a code-7 pulse.
      cycle(1'b1, 1'b1, 3'd7);
      cycle(1'b1, 1'b0, 3'd0);
      cycle(1'b1, 1'b0, 3'd0);
      async_reset();
      cycle(1'b1, 1'b1, 3'd4);
      idle(8);

      // en dropped mid-pulse with code 2 pending.
      cycle(1'b1, 1'b1, 3'd1);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 3'd2);
      n = 0;
      do begin
         cycle(1'b1, 1'b1, 3'd2);
         n++;
      end while (!acc_a && n < 20);
      chk("en_resume_accept", acc_a, 1'b1);
      chk("en_resume_delay",  n,     1);
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/decoder_3to8_pulse.md
Name: decoder_3to8_pulse

Overview:
- Counterpart of the team's 8-to-3 encoder: accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line of an 8-bit output for a programmable number of cycles.
- An optional all-zero gap follows each pulse.
- Used as the strobe/select generator that feeds encoder inputs in lab benches and downstream select logic.
- Fully synchronous datapath on one clock; all outputs registered or decoded from registered state.

Parameters:
- PULSE_LEN, 4: cycles each one-hot output is held; legal range 1..255.
- GAP_LEN, 1: all-zero cycles after each pulse; legal range 0..255.
- CW, 8: width of the internal cycle counter; must hold max(PULSE_LEN, GAP_LEN).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  enables acceptance of new codes; does not abort a pulse in progress.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  3  binary code 0..7.
- out  output  8  one-hot output, bit in_code set while driving; 8'h00 otherwise.
- busy  output  1  high in DRIVE or GAP.
- done  output  1  one-cycle pulse in the final DRIVE cycle of each pulse.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, out=8'h00, counter=0, in_ready=0, busy=0, done=0. Asserting rst_n low mid-pulse clears out immediately, with no done pulse. After rst_n rises, the first accept is possible at the first clk edge with en=1.
- States are IDLE, DRIVE and GAP.
- Accept:
  - An accept occurs on an edge where in_valid && in_ready.
  - On an accept, out <= 8'h01 << in_code, counter <= PULSE_LEN-1 and state <= DRIVE.
- in_ready:
  - High in IDLE when en=1.
  - Also high when en=1 in the last GAP cycle (counter==0).
  - If GAP_LEN==0, also high when en=1 in the last DRIVE cycle (counter==0).
  - Low otherwise.
- Latency: for an accept at edge k, out is one-hot during cycles k+1 .. k+PULSE_LEN (exactly PULSE_LEN cycles).
- DRIVE:
  - While counter != 0, decrement the counter and hold out.
  - When counter==0, done=1 this cycle. At the next edge:
    - If an accept occurs (GAP_LEN==0 only), load the new one-hot value with no zero cycle in between.
    - Else if GAP_LEN>0, out <= 0, counter <= GAP_LEN-1, state <= GAP.
    - Else out <= 0, state <= IDLE.
- GAP:
  - out=0. Decrement the counter.
  - When counter==0: an accept loads DRIVE; otherwise state <= IDLE.
- Throughput: one code per PULSE_LEN+GAP_LEN cycles (minimum 1) under continuous in_valid.
- busy = (state != IDLE).
- done is decoded from registered state; it is never high outside DRIVE.
- en low mid-operation: the current pulse and gap finish normally, the block returns to IDLE, and in_ready stays low.
- in_code is sampled only on an accept; changes at other times have no effect.
- out always has at most one bit set. out is never X after reset; no Z is ever driven.

Decomposition:
- Shared package/header holds:
  - the state encodings (IDLE=2'd0, DRIVE=2'd1, GAP=2'd2);
  - the localparam for the one-hot zero value;
  - a parameter-range check (elaboration error if PULSE_LEN<1 or either length exceeds 2**CW-1).
- One sub-module: dec_3to8, a purely combinational 3-bit binary to 8-bit one-hot decoder. Its output is registered into out on an accept.

Test Plan:
- Reset then code stream 0..7: in_code=3'd5, valid one cycle, PULSE_LEN=4, GAP_LEN=1 -> out=8'h20 for exactly 4 cycles, done high in the 4th, then 8'h00 for 1 cycle, then IDLE; busy high for 5 cycles.
- Sweep in_code 0..7 back-to-back with in_valid held high -> out sequence 01,02,04,…,80, each for 4 cycles separated by one 00 cycle; a new code every 5 cycles.
- GAP_LEN=0, PULSE_LEN=1, continuous valid with codes 3,6 -> out=8'h08 then 8'h40 on consecutive cycles with no 00 between; in_ready stays high.
- Assert rst_n low during cycle 2 of a code-7 pulse -> out=8'h00 immediately (asynchronously), done never pulses, and the next accept works normally.
- Drop en in the middle of a pulse while in_valid stays high with code 2 -> the current pulse completes, in_ready stays 0, and no code-2 pulse occurs until en returns to 1.
- Change in_code while busy (in_valid=0) -> out unchanged; check the one-hot/zero invariant on out every cycle.
